// File: rtl/cook_timer_pkg.sv
// Shared types and constants for the microwave cook timer controller.
package cook_timer_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_ENTRY = 3'd1,
        ST_COOK  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [3:0] QUICK_START_SEC_TENS = 4'd3;
    localparam logic [3:0] DIGIT_MAX_UNITS      = 4'd9;
    localparam logic [3:0] DIGIT_MAX_TENS       = 4'd5;

    // A keypad code is a usable digit only when it is valid BCD.
    function automatic logic is_bcd_key(input logic [3:0] code);
        return (code <= 4'd9);
    endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD display digit: loadable, shiftable, and decrementing with wrap to MAX.
module bcd_down_digit #(
    parameter logic [3:0] MAX = 4'd9
) (
    input  logic       clock,
    input  logic       clearn,
    input  logic       load,
    input  logic [3:0] load_value,
    input  logic       dec_en,
    input  logic       shift_en,
    input  logic [3:0] shift_in,
    output logic [3:0] value,
    output logic       borrow_out,
    output logic       zero
);

    logic [3:0] value_r;

    // Digit register: load beats shift, shift beats decrement.
    always_ff @(posedge clock or negedge clearn) begin
        if (!clearn) begin
            value_r <= 4'd0;
        end else if (load) begin
            value_r <= load_value;
        end else if (shift_en) begin
            value_r <= shift_in;
        end else if (dec_en) begin
            value_r <= (value_r == 4'd0) ? MAX : (value_r - 4'd1);
        end else begin
            value_r <= value_r;
        end
    end

    assign value      = value_r;
    assign zero       = (value_r == 4'd0);
    assign borrow_out = dec_en && (value_r == 4'd0);

endmodule

// File: rtl/cook_timer_controller.sv
// Cook timer: keypad time entry, start/stop/door handling and mm:ss BCD countdown.
module cook_timer_controller
    import cook_timer_pkg::*;
(
    input  logic               clock,
    input  logic               clearn,
    input  logic               tick_1hz,
    input  logic               keypad_valid,
    input  logic [3:0]         keypad_digit,
    input  logic               startn,
    input  logic               stopn,
    input  logic               door_closed,
    output logic [3:0]         min_tens,
    output logic [3:0]         min_units,
    output logic [3:0]         sec_tens,
    output logic [3:0]         sec_units,
    output logic               mag_on,
    output logic               done,
    output logic [STATE_W-1:0] state
);

    logic       start_cur_r, start_prev_r, stop_cur_r, stop_prev_r;
    logic       start_press_s, stop_press_s;
    state_t     state_r, state_next_s, state_final_s;
    logic       dec_s, shift_s, clear_s, quick_s, load_s, underflow_s;
    logic       key_ok_s, time_zero_s, time_one_s;
    logic [3:0] su_s, st_s, mu_s, mt_s;
    logic       su_b_s, st_b_s, mu_b_s;
    logic       su_z_s, st_z_s, mu_z_s, mt_z_s;
    logic       mag_on_r, done_r;

    // Key samples; reset to the released level so no press is seen out of reset.
    always_ff @(posedge clock or negedge clearn) begin
        if (!clearn) begin
            start_cur_r  <= 1'b1;
            start_prev_r <= 1'b1;
            stop_cur_r   <= 1'b1;
            stop_prev_r  <= 1'b1;
        end else begin
            start_cur_r  <= startn;
            start_prev_r <= start_cur_r;
            stop_cur_r   <= stopn;
            stop_prev_r  <= stop_cur_r;
        end
    end

    assign start_press_s = start_prev_r & ~start_cur_r;
    assign stop_press_s  = stop_prev_r & ~stop_cur_r;

    assign time_zero_s = mt_z_s & mu_z_s & st_z_s & su_z_s;
    assign time_one_s  = mt_z_s & mu_z_s & st_z_s & (su_s == 4'd1);
    assign key_ok_s    = keypad_valid && is_bcd_key(keypad_digit) && (su_s <= DIGIT_MAX_TENS);

    // Next state and datapath commands, priority stop > door > tick > start > keypad.
    always_comb begin
        state_next_s = state_r;
        dec_s        = 1'b0;
        shift_s      = 1'b0;
        clear_s      = 1'b0;
        quick_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (stop_press_s) begin
                    clear_s      = 1'b1;
                    state_next_s = ST_IDLE;
                end else if (start_press_s && door_closed) begin
                    quick_s      = 1'b1;
                    state_next_s = ST_COOK;
                end else if (key_ok_s) begin
                    shift_s      = 1'b1;
                    state_next_s = ST_ENTRY;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ENTRY: begin
                if (stop_press_s) begin
                    clear_s      = 1'b1;
                    state_next_s = ST_IDLE;
                end else if (start_press_s && door_closed && !time_zero_s) begin
                    state_next_s = ST_COOK;
                end else if (key_ok_s) begin
                    shift_s      = 1'b1;
                    state_next_s = ST_ENTRY;
                end else begin
                    state_next_s = ST_ENTRY;
                end
            end
            ST_COOK: begin
                if (stop_press_s || !door_closed) begin
                    state_next_s = ST_PAUSE;
                end else if (tick_1hz && !time_zero_s) begin
                    dec_s        = 1'b1;
                    state_next_s = time_one_s ? ST_DONE : ST_COOK;
                end else begin
                    state_next_s = ST_COOK;
                end
            end
            ST_PAUSE: begin
                if (stop_press_s) begin
                    clear_s      = 1'b1;
                    state_next_s = ST_IDLE;
                end else if (start_press_s && door_closed) begin
                    state_next_s = ST_COOK;
                end else begin
                    state_next_s = ST_PAUSE;
                end
            end
            ST_DONE: begin
                if (stop_press_s || start_press_s || !door_closed) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: begin
                clear_s      = 1'b1;
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // A borrow out of the top digit must never wrap the display; clamp to 00:00 and finish.
    assign state_final_s = underflow_s ? ST_DONE : state_next_s;
    assign load_s        = clear_s | quick_s | underflow_s;

    // State and registered status outputs, all updated on the same edge.
    always_ff @(posedge clock or negedge clearn) begin
        if (!clearn) begin
            state_r  <= ST_IDLE;
            mag_on_r <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_final_s;
            mag_on_r <= (state_final_s == ST_COOK);
            done_r   <= (state_final_s == ST_DONE);
        end
    end

    bcd_down_digit #(.MAX(DIGIT_MAX_UNITS)) u_sec_units (
        .clock(clock), .clearn(clearn), .load(load_s), .load_value(4'd0),
        .dec_en(dec_s), .shift_en(shift_s), .shift_in(keypad_digit),
        .value(su_s), .borrow_out(su_b_s), .zero(su_z_s)
    );

    bcd_down_digit #(.MAX(DIGIT_MAX_TENS)) u_sec_tens (
        .clock(clock), .clearn(clearn), .load(load_s),
        .load_value(quick_s ? QUICK_START_SEC_TENS : 4'd0),
        .dec_en(su_b_s), .shift_en(shift_s), .shift_in(su_s),
        .value(st_s), .borrow_out(st_b_s), .zero(st_z_s)
    );

    bcd_down_digit #(.MAX(DIGIT_MAX_UNITS)) u_min_units (
        .clock(clock), .clearn(clearn), .load(load_s), .load_value(4'd0),
        .dec_en(st_b_s), .shift_en(shift_s), .shift_in(st_s),
        .value(mu_s), .borrow_out(mu_b_s), .zero(mu_z_s)
    );

    bcd_down_digit #(.MAX(DIGIT_MAX_UNITS)) u_min_tens (
        .clock(clock), .clearn(clearn), .load(load_s), .load_value(4'd0),
        .dec_en(mu_b_s), .shift_en(shift_s), .shift_in(mu_s),
        .value(mt_s), .borrow_out(underflow_s), .zero(mt_z_s)
    );

    assign min_tens  = mt_s;
    assign min_units = mu_s;
    assign sec_tens  = st_s;
    assign sec_units = su_s;
    assign mag_on    = mag_on_r;
    assign done      = done_r;
    assign state     = state_r;

endmodule

// File: doc/cook_timer_controller.md
COOK_TIMER_CONTROLLER -- requirements
Module: cook_timer_controller

Interface
REQ-001 The block SHALL have ports: clock  in  1  system clock, all state changes on rising edge.
REQ-002 The block SHALL have ports: clearn  in  1  reset, asynchronous, active-low.
REQ-003 The block SHALL have ports: tick_1hz  in  1  one-clock-wide enable pulse, once per second.
REQ-004 The block SHALL have ports: keypad_valid  in  1  high for one clock when keypad_digit is valid.
REQ-005 The block SHALL have ports: keypad_digit  in  4  BCD key code; values >9 are ignored.
REQ-006 The block SHALL have ports: startn, stopn  in  1 each  debounced start and stop keys, active-low.
REQ-007 The block SHALL have ports: door_closed  in  1  1 = door closed.
REQ-008 The block SHALL have ports: min_tens, min_units, sec_tens, sec_units  out  4 each  BCD time display mm:ss.
REQ-009 The block SHALL have ports: mag_on  out  1  magnetron enable; done  out  1  cook finished; state  out  3  current state code.

Function
REQ-010 The block SHALL act on key falling edges only: startn or stopn is registered, and a press is a cycle where the previous sample is 1 and the current sample is 0.
REQ-011 The block SHALL implement states IDLE, ENTRY, COOK, PAUSE and DONE.
REQ-012 In IDLE or ENTRY, a keypad_valid with digit <=9 and current sec_units <=5 SHALL shift the time left one digit in the next clock: min_tens<=min_units, min_units<=sec_tens, sec_tens<=sec_units, sec_units<=digit. Otherwise the key SHALL be ignored. IDLE SHALL go to ENTRY on an accepted key.
REQ-013 Start in ENTRY with a nonzero time and door_closed=1 SHALL go to COOK. Start with a zero time, or with the door open, SHALL be ignored.
REQ-014 Start in IDLE with door_closed=1 SHALL load 00:30 (quick start) and go to COOK in the same edge.
REQ-015 In COOK, tick_1hz SHALL decrement mm:ss by one second with BCD borrow. The digit wrap values are: sec_units 0->9, sec_tens 0->5, min_units 0->9, min_tens 0->9. A borrow SHALL propagate only when every lower digit is 0.
REQ-016 A tick at 00:01 SHALL give 00:00 and state DONE on the same edge.
REQ-017 Stop in COOK, or door_closed=0 in COOK, SHALL go to PAUSE with the time held.
REQ-018 Start in PAUSE with door_closed=1 SHALL resume COOK.
REQ-019 Stop in PAUSE or ENTRY SHALL clear the time to 00:00 and go to IDLE.
REQ-020 In DONE, done=1 and the time SHALL hold 00:00. A stop press, a start press or door_closed=0 SHALL go to IDLE.
REQ-021 When events coincide, priority SHALL be: stop > door open > tick > start > keypad. A tick in the same cycle as stop or door-open SHALL NOT decrement.
REQ-022 mag_on SHALL equal (state==COOK) and done SHALL equal (state==DONE). Both SHALL be registered, with no combinational path from the inputs.
REQ-023 Ticks outside COOK SHALL be ignored. Keypad input outside IDLE and ENTRY SHALL be ignored.
REQ-024 The time SHALL never leave the range 00:00..99:59, and every digit SHALL always be valid BCD.

Reset
REQ-025 clearn=0 SHALL immediately force: state=IDLE, all digits 0, mag_on=0, done=0, and the key-edge registers =1 (released).
REQ-026 A reset during COOK SHALL drop mag_on asynchronously, with no clock needed.
REQ-027 After clearn rises, the first edge SHALL NOT detect a key press unless the key was released for one sample first.

Structure
REQ-028 Package cook_timer_pkg SHALL hold: the state encodings (IDLE=0, ENTRY=1, COOK=2, PAUSE=3, DONE=4), QUICK_START_SEC_TENS=3, the digit maximum values (9 and 5), and the state width.
REQ-029 Sub-module bcd_down_digit (parameter MAX) SHALL implement one digit. Inputs: load, load value, decrement enable, shift-in. Outputs: value, borrow-out (enable && value==0), zero.
REQ-030 The controller SHALL instantiate four bcd_down_digit instances chained by borrow, plus the FSM and edge detectors.

Verification
REQ-031 Keys 1,3,0 then start, door closed -> display 01:30, COOK, mag_on=1; one tick -> 01:29.
REQ-032 Time 01:00, tick -> 00:59. Time 10:00, tick -> 09:59. Time 00:01, tick -> 00:00, DONE, done=1, mag_on=0 on the same edge.
REQ-033 Start in IDLE, door closed -> 00:30, COOK. Same with door open -> stays IDLE at 00:00.
REQ-034 In COOK at 00:45, door opens in the same cycle as a tick -> PAUSE at 00:45. Door closes, then start -> COOK at 00:45.
REQ-035 Keys 7 then 8 -> 00:07, then the 8 is ignored (sec_units 7 >5), display stays 00:07. Key value 12 is ignored.
REQ-036 clearn pulsed low mid-COOK at 05:17 -> mag_on=0 before the next clock edge, IDLE, 00:00.
